// File: rtl/mem_responder_pkg.sv
// Shared memory-protocol types for the responder slice.
// Tags, blocks, addresses and command encodings used across the memory side.
package mem_responder_pkg;

    localparam int NUM_MEM_TAGS = 15;
    localparam int MEM_TAG_W    = $clog2(NUM_MEM_TAGS + 1);

    typedef logic [MEM_TAG_W-1:0] mem_tag_t;
    typedef logic [63:0]          mem_block_t;
    typedef logic [31:0]          addr_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_command_t;

endpackage

// File: rtl/mem_tag_pool.sv
// Free-tag pool: lowest-numbered free tag is granted; tag i lives in bit i-1.
// A tag freed this cycle only shows up as free from the next cycle on.
module mem_tag_pool
    import mem_responder_pkg::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     alloc_req,
    output logic     alloc_gnt,
    output mem_tag_t alloc_tag,
    input  mem_tag_t free_tag
);

    logic [NUM_TAGS-1:0] free_q;
    logic [NUM_TAGS-1:0] free_d;
    mem_tag_t            lowest;

    // Priority-encode the registered free vector, lowest tag wins.
    always_comb begin
        lowest = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_q[i]) lowest = mem_tag_t'(i + 1);
        end
        alloc_gnt = alloc_req && (free_q != '0);
        alloc_tag = alloc_gnt ? lowest : '0;
    end

    // Clear the granted bit and set the bit of the returning tag.
    always_comb begin
        free_d = free_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (alloc_gnt && lowest == mem_tag_t'(i + 1)) free_d[i] = 1'b0;
            if (free_tag == mem_tag_t'(i + 1)) free_d[i] = 1'b1;
        end
    end

    // Free-vector register; reset makes every tag available.
    always_ff @(posedge clock) begin
        if (reset) free_q <= '1;
        else       free_q <= free_d;
    end

endmodule

// File: rtl/mem_responder.sv
// Tagged memory-side responder: block store plus fixed-latency return pipe.
// Load data is snapshotted at accept and returned LATENCY cycles later.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS,
    parameter int LATENCY  = 4,
    parameter int DEPTH    = 256
) (
    input  logic         clock,
    input  logic         reset,
    input  mem_command_t req_command,
    input  addr_t        req_addr,
    input  mem_block_t   req_data,
    output logic         req_accepted,
    output mem_tag_t     req_tag,
    output mem_block_t   resp_data,
    output mem_tag_t     resp_tag
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        mem_tag_t   tag;
        mem_block_t data;
    } ret_entry_t;

    mem_block_t       store_q [DEPTH];
    ret_entry_t       pipe_q  [LATENCY];
    ret_entry_t       pipe_in;
    logic [IDX_W-1:0] idx;
    logic             is_load;
    logic             is_store;
    logic             load_gnt;
    mem_tag_t         load_tag;

    assign idx      = req_addr[3 +: IDX_W];
    assign is_load  = (req_command == MEM_LOAD);
    assign is_store = (req_command == MEM_STORE);

    mem_tag_pool #(
        .NUM_TAGS (NUM_TAGS)
    ) u_pool (
        .clock     (clock),
        .reset     (reset),
        .alloc_req (is_load),
        .alloc_gnt (load_gnt),
        .alloc_tag (load_tag),
        .free_tag  (resp_tag)
    );

    assign req_accepted = is_store || load_gnt;
    assign req_tag      = load_tag;
    assign resp_tag     = pipe_q[LATENCY-1].tag;
    assign resp_data    = pipe_q[LATENCY-1].data;

    // Build the pipe entry; the read sees pre-store data on a same-index write.
    always_comb begin
        pipe_in = '0;
        if (load_gnt) begin
            pipe_in.tag  = load_tag;
            pipe_in.data = store_q[idx];
        end
    end

    // Block store; written only by accepted stores.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
        end else if (is_store) begin
            store_q[idx] <= req_data;
        end
    end

    // Return pipeline; reset drops everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default instance plus a LATENCY=20 one.
// Inputs change #1 after posedge; outputs are sampled at negedge.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic         clock = 1'b0;
    logic         reset;

    mem_command_t a_cmd;
    addr_t        a_addr;
    mem_block_t   a_data;
    logic         a_acc;
    mem_tag_t     a_stag;
    mem_block_t   a_rdata;
    mem_tag_t     a_rtag;

    mem_command_t b_cmd;
    addr_t        b_addr;
    mem_block_t   b_data;
    logic         b_acc;
    mem_tag_t     b_stag;
    mem_block_t   b_rdata;
    mem_tag_t     b_rtag;

    int total = 0;
    int bad   = 0;

    localparam mem_block_t BEEF = 64'hDEADBEEF_CAFEF00D;
    localparam mem_block_t PAT1 = 64'h1111_2222_3333_4444;
    localparam mem_block_t PATW = 64'h0123_4567_89AB_CDEF;

    always #5 clock = ~clock;

    mem_responder u_dut (
        .clock        (clock),
        .reset        (reset),
        .req_command  (a_cmd),
        .req_addr     (a_addr),
        .req_data     (a_data),
        .req_accepted (a_acc),
        .req_tag      (a_stag),
        .resp_data    (a_rdata),
        .resp_tag     (a_rtag)
    );

    mem_responder #(
        .NUM_TAGS (15),
        .LATENCY  (20),
        .DEPTH    (256)
    ) u_dut20 (
        .clock        (clock),
        .reset        (reset),
        .req_command  (b_cmd),
        .req_addr     (b_addr),
        .req_data     (b_data),
        .req_accepted (b_acc),
        .req_tag      (b_stag),
        .resp_data    (b_rdata),
        .resp_tag     (b_rtag)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic drv_a(input mem_command_t c, input addr_t a,
                         input mem_block_t d);
        a_cmd  = c;
        a_addr = a;
        a_data = d;
    endtask

    task automatic drv_b(input mem_command_t c, input addr_t a);
        b_cmd  = c;
        b_addr = a;
        b_data = '0;
    endtask

    task automatic idle_a(input int n);
        drv_a(MEM_NONE, '0, '0);
        for (int i = 0; i < n; i++) adv();
    endtask

    initial begin
        reset = 1'b1;
        drv_a(MEM_NONE, '0, '0);
        drv_b(MEM_NONE, '0);
        adv();
        adv();
        reset = 1'b0;

        // reset then idle
        mid();
        check("rst_resp_tag",  64'(a_rtag),  64'd0);
        check("rst_resp_data", a_rdata,      64'd0);
        check("rst_acc",       64'(a_acc),   64'd0);
        check("rst_req_tag",   64'(a_stag),  64'd0);
        check("rst_b_tag",     64'(b_rtag),  64'd0);
        adv();
        adv();
        drv_a(MEM_LOAD, 32'h100, '0);
        mid();
        check("ld100_acc", 64'(a_acc),  64'd1);
        check("ld100_tag", 64'(a_stag), 64'd1);
        adv();
        drv_a(MEM_NONE, '0, '0);
        for (int i = 3; i < 6; i++) begin
            mid();
            check("ld100_early", 64'(a_rtag), 64'd0);
            adv();
        end
        mid();
        check("ld100_rtag",  64'(a_rtag), 64'd1);
        check("ld100_rdata", a_rdata,     64'd0);
        adv();
        mid();
        check("ld100_once", 64'(a_rtag), 64'd0);
        adv();

        // store then load, low address bits ignored
        drv_a(MEM_STORE, 32'h40, BEEF);
        mid();
        check("st40_acc", 64'(a_acc),  64'd1);
        check("st40_tag", 64'(a_stag), 64'd0);
        adv();
        drv_a(MEM_LOAD, 32'h44, '0);
        mid();
        check("ld44_tag", 64'(a_stag), 64'd1);
        adv();
        idle_a(3);
        mid();
        check("ld44_rtag",  64'(a_rtag), 64'd1);
        check("ld44_rdata", a_rdata,     BEEF);
        adv();

        // snapshot at accept vs later store
        drv_a(MEM_LOAD, 32'h80, '0);
        mid();
        check("ld80a_tag", 64'(a_stag), 64'd1);
        adv();
        drv_a(MEM_STORE, 32'h80, PAT1);
        adv();
        drv_a(MEM_LOAD, 32'h80, '0);
        mid();
        check("ld80b_tag", 64'(a_stag), 64'd2);
        adv();
        idle_a(1);
        mid();
        check("ld80a_rtag",  64'(a_rtag), 64'd1);
        check("ld80a_rdata", a_rdata,     64'd0);
        adv();
        mid();
        check("ld80_gap", 64'(a_rtag), 64'd0);
        adv();
        mid();
        check("ld80b_rtag",  64'(a_rtag), 64'd2);
        check("ld80b_rdata", a_rdata,     PAT1);
        adv();

        // index wrap-around
        drv_a(MEM_STORE, 32'h800, PATW);
        adv();
        drv_a(MEM_LOAD, 32'h000, '0);
        mid();
        check("wrap_tag1", 64'(a_stag), 64'd1);
        adv();
        drv_a(MEM_LOAD, 32'h088, '0);
        mid();
        check("wrap_tag2", 64'(a_stag), 64'd2);
        adv();
        idle_a(2);
        mid();
        check("wrap_rtag1",  64'(a_rtag), 64'd1);
        check("wrap_rdata1", a_rdata,     PATW);
        adv();
        mid();
        check("wrap_rtag2",  64'(a_rtag), 64'd2);
        check("wrap_rdata2", a_rdata,     64'd0);
        adv();
        idle_a(1);

        // reset while loads are in flight
        for (int i = 0; i < 3; i++) begin
            drv_a(MEM_LOAD, addr_t'(i * 8), '0);
            mid();
            check("mf_tag", 64'(a_stag), 64'(i + 1));
            adv();
        end
        drv_a(MEM_NONE, '0, '0);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mid();
            check("mf_quiet", 64'(a_rtag), 64'd0);
            adv();
        end
        drv_a(MEM_LOAD, 32'h000, '0);
        mid();
        check("mf_newtag", 64'(a_stag), 64'd1);
        adv();
        idle_a(3);
        mid();
        check("mf_rtag",  64'(a_rtag), 64'd1);
        check("mf_rdata", a_rdata,     64'd0);
        adv();

        // pool exhaustion on the LATENCY=20 instance
        for (int i = 0; i < 15; i++) begin
            drv_b(MEM_LOAD, addr_t'(i * 8));
            mid();
            check("ex_acc", 64'(b_acc),  64'd1);
            check("ex_tag", 64'(b_stag), 64'(i + 1));
            adv();
        end
        for (int i = 15; i < 20; i++) begin
            drv_b(MEM_LOAD, 32'h0);
            mid();
            check("ex_refuse_acc", 64'(b_acc),  64'd0);
            check("ex_refuse_tag", 64'(b_stag), 64'd0);
            check("ex_no_resp",    64'(b_rtag), 64'd0);
            adv();
        end
        mid();
        check("ex_ret_rtag", 64'(b_rtag), 64'd1);
        check("ex_ret_acc",  64'(b_acc),  64'd0);
        check("ex_ret_tag",  64'(b_stag), 64'd0);
        adv();
        mid();
        check("ex_regrant_acc", 64'(b_acc),  64'd1);
        check("ex_regrant_tag", 64'(b_stag), 64'd1);
        check("ex_next_rtag",   64'(b_rtag), 64'd2);
        adv();
        drv_b(MEM_NONE, '0);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
